// File: rtl/twin_reg_sched_pkg.sv
// twin_reg_sched_pkg
// Shared definitions for the twin register scheduler:
//   - state_t and the FSM state constants (ST_ARB, ST_CLR1, ST_CLR2)
//   - requester ids (REQ_A, REQ_B), which are also grant-vector bit positions
//   - slot ids (SLOT_Q1, SLOT_Q2), matching the requesters' dest encoding
package twin_reg_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ARB  = 2'd0;
  localparam state_t ST_CLR1 = 2'd1;
  localparam state_t ST_CLR2 = 2'd2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic SLOT_Q1 = 1'b0;
  localparam logic SLOT_Q2 = 1'b1;

endpackage

// File: rtl/twin_reg_sched_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Purely combinational.
//   req[1:0]   : request vector, bit REQ_A = A, bit REQ_B = B
//   en         : when low, no grant is issued
//   last_grant : id of the requester granted most recently (held by the parent)
//   gnt[1:0]   : one-hot grant, or zero
// On a tie the requester that is not last_grant wins. A grant is only
// issued to a requester whose req bit is set.
module rr_arb2
  import twin_reg_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/twin_reg_sched.sv
// twin_reg_sched
// Scheduler and controller for a shared pair of WIDTH-bit slots
// (slot 0 -> q1, slot 1 -> q2). Requesters A and B write through
// valid/ready handshakes with round-robin fairness; clr_req starts a
// two-cycle clear (q1 first, then q2).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_dest/a_data    requester A write request
//   a_ready                  A accepted this cycle (combinational)
//   b_valid/b_dest/b_data    requester B write request
//   b_ready                  B accepted this cycle (combinational)
//   clr_req                  clear request, sampled in ARB only
//   clr_busy                 high in CLR1 and CLR2
//   q1, q2                   slot contents (registered)
//   upd1, upd2               one-cycle pulse with each newly written value
//   dbg_state                current FSM state (ST_ARB / ST_CLR1 / ST_CLR2)
//
// Handshake: a transfer happens in a cycle where valid && ready. ready is
// never raised without valid; the requester keeps dest and data stable
// while valid is high and ready is low.
//
// Build option: TWIN_REG_SCHED_DUAL_EN lets A and B both be granted in one
// ARB cycle when they target different slots (last_grant is left alone).
module twin_reg_sched
  import twin_reg_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_dest,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_dest,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             upd1,
  output logic             upd2,
  output state_t           dbg_state
);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       arb_en;
  logic       dual;
  logic [1:0] gnt;
  logic       wr_a;
  logic       wr_b;
  logic       wr_q1;
  logic       wr_q2;
  logic [WIDTH-1:0] d_q1;
  logic [WIDTH-1:0] d_q2;

  // Grants only in ARB without a pending clear; rst also suppresses ready
  // so nothing looks accepted during reset.
  assign arb_en = !rst && (state == ST_ARB) && !clr_req;

  rr_arb2 u_arb (
    .req        ({b_valid, a_valid}),
    .en         (arb_en),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

`ifdef TWIN_REG_SCHED_DUAL_EN
  assign dual = arb_en && a_valid && b_valid && (a_dest != b_dest);
`else
  assign dual = 1'b0;
`endif

  assign a_ready = gnt[REQ_A] | dual;
  assign b_ready = gnt[REQ_B] | dual;

  assign wr_a = a_valid && a_ready;
  assign wr_b = b_valid && b_ready;

  // The arbiter never lets two writes land on the same slot in one cycle.
  assign wr_q1 = (wr_a && a_dest == SLOT_Q1) || (wr_b && b_dest == SLOT_Q1);
  assign wr_q2 = (wr_a && a_dest == SLOT_Q2) || (wr_b && b_dest == SLOT_Q2);
  assign d_q1  = (wr_a && a_dest == SLOT_Q1) ? a_data : b_data;
  assign d_q2  = (wr_a && a_dest == SLOT_Q2) ? a_data : b_data;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ARB:  state_nxt = clr_req ? ST_CLR1 : ST_ARB;
      ST_CLR1: state_nxt = ST_CLR2;
      ST_CLR2: state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      last_grant <= REQ_B;
      q1         <= '0;
      q2         <= '0;
      upd1       <= 1'b0;
      upd2       <= 1'b0;
    end else begin
      state <= state_nxt;
      upd1  <= wr_q1;
      upd2  <= wr_q2;
      // Writes and clears never coincide: no grants outside ARB.
      if (wr_q1)                 q1 <= d_q1;
      else if (state == ST_CLR1) q1 <= '0;
      if (wr_q2)                 q2 <= d_q2;
      else if (state == ST_CLR2) q2 <= '0;
      // A dual grant keeps the round-robin pointer where it was.
      if ((|gnt) && !dual)
        last_grant <= gnt[REQ_B] ? REQ_B : REQ_A;
    end
  end

  assign clr_busy  = (state == ST_CLR1) || (state == ST_CLR2);
  assign dbg_state = state;

endmodule

// File: tb/tb_twin_reg_sched.sv
// tb_twin_reg_sched
// Directed scenarios followed by random traffic, all checked against a
// cycle-level behavioural model of the scheduler kept in the bench.
// Honours TWIN_REG_SCHED_DUAL_EN the same way the design does.
module tb_twin_reg_sched;
  import twin_reg_sched_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_dest, b_valid, b_dest, clr_req;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, clr_busy, upd1, upd2;
  logic [W-1:0] q1, q2;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [W-1:0] m_q1, m_q2;
  logic         m_upd1, m_upd2;
  int           m_clr_left;  // clear cycles still to run: 2 = q1 next, 1 = q2 next
  logic         m_last_b;    // 1 when B was granted most recently

  // ready values seen in the most recent step
  logic obs_ar, obs_br;

  twin_reg_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_dest    (a_dest),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_dest    (b_dest),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .q1        (q1),
    .q2        (q2),
    .upd1      (upd1),
    .upd2      (upd2),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a rising edge, check the
  // combinational readies mid-cycle, then check registered outputs after
  // the next rising edge.
  task automatic step(input logic r, input logic av, input logic ad, input logic [W-1:0] adt,
                      input logic bv, input logic bd, input logic [W-1:0] bdt, input logic cr);
    logic ea, eb, dual_ok;
    rst = r; a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt; clr_req = cr;
    #1;
`ifdef TWIN_REG_SCHED_DUAL_EN
    dual_ok = (ad != bd);
`else
    dual_ok = 1'b0;
`endif
    ea = 1'b0; eb = 1'b0;
    if (!r && m_clr_left == 0 && !cr) begin
      if (av && bv && dual_ok) begin
        ea = 1'b1; eb = 1'b1;
      end else if (av && bv) begin
        if (m_last_b) ea = 1'b1; else eb = 1'b1;
      end else begin
        ea = av; eb = bv;
      end
    end
    obs_ar = a_ready; obs_br = b_ready;
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    @(posedge clk); #1;
    if (r) begin
      m_q1 = '0; m_q2 = '0; m_upd1 = 0; m_upd2 = 0; m_clr_left = 0; m_last_b = 1;
    end else begin
      m_upd1 = (ea && ad == 0) || (eb && bd == 0);
      m_upd2 = (ea && ad == 1) || (eb && bd == 1);
      if (ea && ad == 0) m_q1 = adt;
      if (eb && bd == 0) m_q1 = bdt;
      if (ea && ad == 1) m_q2 = adt;
      if (eb && bd == 1) m_q2 = bdt;
      if (m_clr_left == 2) begin
        m_q1 = '0; m_clr_left = 1;
      end else if (m_clr_left == 1) begin
        m_q2 = '0; m_clr_left = 0;
      end else if (cr) begin
        m_clr_left = 2;
      end
      if (ea != eb) m_last_b = eb;
    end
    check("q1", q1, m_q1);
    check("q2", q2, m_q2);
    check("upd1", upd1, m_upd1);
    check("upd2", upd2, m_upd2);
    check("clr_busy", clr_busy, (m_clr_left != 0));
  endtask

  initial begin
    logic         pa, pb, pad, pbd, r, cr;
    logic [W-1:0] pat, pbt;

    rst = 1; a_valid = 0; a_dest = 0; a_data = 0;
    b_valid = 0; b_dest = 0; b_data = 0; clr_req = 0;
    m_q1 = 0; m_q2 = 0; m_upd1 = 0; m_upd2 = 0; m_clr_left = 0; m_last_b = 1;
    @(posedge clk); #1;

    // reset with both requesters valid
    step(1, 1, 0, 8'hAA, 1, 1, 8'hBB, 0);
    step(1, 1, 0, 8'hAA, 1, 1, 8'hBB, 0);
    check("rst_q1", q1, 0);
    check("rst_q2", q2, 0);
    check("rst_upd", {upd1, upd2}, 0);
    check("rst_busy", clr_busy, 0);

    // first tie after reset goes to A
    step(0, 1, 0, 8'h55, 1, 0, 8'h66, 0);
    check("first_tie_a", obs_ar, 1);
    check("first_tie_b", obs_br, 0);
    step(0, 0, 0, 8'h00, 1, 0, 8'h66, 0);

    // single write
    step(0, 1, 0, 8'hA5, 0, 0, 8'h00, 0);
    check("single_ready", obs_ar, 1);
    check("single_q1", q1, 8'hA5);
    check("single_upd1", upd1, 1);
    check("single_q2", q2, 0);

    // put the pointer on B, then hold a same-slot tie: A,B,A,B,A,B
    step(0, 0, 0, 8'h00, 1, 0, 8'h44, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 8'h11, 1, 1, 8'h22, 0);
      check("rr_a_ready", obs_ar, (i % 2 == 0));
      check("rr_q2", q2, (i % 2 == 0) ? 8'h11 : 8'h22);
    end

    // clear sequence
    step(0, 1, 0, 8'h3C, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1, 1, 8'hC3, 0);
    step(0, 1, 0, 8'h77, 0, 0, 8'h00, 1);
    check("clr_no_grant", obs_ar, 0);
    check("clr_busy_1", clr_busy, 1);
    check("clr_q1_held", q1, 8'h3C);
    step(0, 1, 0, 8'h77, 0, 0, 8'h00, 0);
    check("clr1_no_grant", obs_ar, 0);
    check("clr1_q1", q1, 0);
    check("clr_busy_2", clr_busy, 1);
    step(0, 1, 0, 8'h77, 0, 0, 8'h00, 0);
    check("clr2_q2", q2, 0);
    check("clr_done", clr_busy, 0);
    step(0, 1, 0, 8'h77, 0, 0, 8'h00, 0);
    check("post_clr_grant", obs_ar, 1);
    check("post_clr_q1", q1, 8'h77);

    // reset during CLR1
    step(0, 0, 0, 8'h00, 1, 1, 8'h5A, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    check("rstclr_busy", clr_busy, 0);
    check("rstclr_q", {q1, q2}, 0);
    check("rstclr_state", dbg_state, ST_ARB);

    // A and B to different slots in the same cycle
    step(0, 1, 0, 8'h01, 1, 1, 8'h02, 0);
`ifdef TWIN_REG_SCHED_DUAL_EN
    check("dual_ready", {obs_ar, obs_br}, 2'b11);
    check("dual_q", {q1, q2}, 16'h0102);
    check("dual_upd", {upd1, upd2}, 2'b11);
`else
    check("dual_ready", {obs_ar, obs_br}, 2'b10);
    check("dual_q1", q1, 8'h01);
    check("dual_upd", {upd1, upd2}, 2'b10);
    step(0, 0, 0, 8'h00, 1, 1, 8'h02, 0);
    check("dual_b_ready", obs_br, 1);
    check("dual_q2", q2, 8'h02);
    check("dual_upd2", upd2, 1);
`endif

    // random traffic; pending requests keep dest/data until accepted
    pa = 0; pb = 0; pad = 0; pbd = 0; pat = 0; pbt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; pad = 1'($urandom_range(0, 1)); pat = 8'($urandom_range(0, 255));
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; pbd = 1'($urandom_range(0, 1)); pbt = 8'($urandom_range(0, 255));
      end
      cr = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 59) == 0);
      step(r, pa, pad, pat, pb, pbd, pbt, cr);
      if (obs_ar) pa = 0;
      if (obs_br) pb = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
